// File: rtl/btn_ctrl_if.sv
//------------------------------------------------------------------------------
// btn_ctrl_if : button inputs and debounced control outputs of btn_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface btn_ctrl_if #(
  parameter int N_BTN = 4
) ();
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_btn_db;
  logic [N_BTN-1:0] o_btn_press;
  logic             o_mux_sel;
  logic             o_shift_dir;
  logic [1:0]       o_color_sel;
  logic             o_run;

  modport master (
    output i_btn,
    input  o_btn_db, o_btn_press, o_mux_sel, o_shift_dir, o_color_sel, o_run
  );

  modport slave (
    input  i_btn,
    output o_btn_db, o_btn_press, o_mux_sel, o_shift_dir, o_color_sel, o_run
  );
endinterface

`default_nettype wire

// File: rtl/btn_ctrl.sv
//------------------------------------------------------------------------------
// btn_ctrl : synchronise and debounce push-buttons, one control update per press
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_ctrl #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 1_250_000
) (
  input  wire logic  clk,
  input  wire logic  i_ck_reset,
  btn_ctrl_if.slave  bus
);

  localparam int             CNT_W      = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_db;
  logic [N_BTN-1:0] r_press;
  logic [CNT_W-1:0] r_cnt [N_BTN];

  logic             r_mux_sel;
  logic             r_shift_dir;
  logic [1:0]       r_color_sel;
  logic             r_run;

  // Any return of the synchronised level to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (i_ck_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.i_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_BTN; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_cnt_last) begin
          r_db[i]    <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_press[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_ck_reset) begin
      r_mux_sel   <= 1'b0;
      r_shift_dir <= 1'b0;
      r_color_sel <= 2'd0;
      r_run       <= 1'b1;
    end else begin
      if (r_press[0]) r_mux_sel   <= ~r_mux_sel;
      if (r_press[1]) r_shift_dir <= ~r_shift_dir;
      if (r_press[2]) r_color_sel <= (r_color_sel == 2'd2) ? 2'd0 : r_color_sel + 2'd1;
      if (r_press[3]) r_run       <= ~r_run;
    end
  end

  assign bus.o_btn_db    = r_db;
  assign bus.o_btn_press = r_press;
  assign bus.o_mux_sel   = r_mux_sel;
  assign bus.o_shift_dir = r_shift_dir;
  assign bus.o_color_sel = r_color_sel;
  assign bus.o_run       = r_run;

endmodule

`default_nettype wire

// File: tb/tb_btn_ctrl.sv
//------------------------------------------------------------------------------
// tb_btn_ctrl : random and directed button stimulus against a history-based model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_btn_ctrl;

  localparam int DB = 4;

  logic clk;
  logic rst;

  btn_ctrl_if #(.N_BTN(4)) bif ();

  btn_ctrl #(.N_BTN(4), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .i_ck_reset (rst),
    .bus        (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic       mux;
    logic       dir;
    logic [1:0] col;
    logic       run;
  } ev_t;

  ev_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a level is accepted once the synchronised input has held
  // the same differing value for DB consecutive samples.
  logic [3:0] m_h1, m_h2, m_prev_s, m_db;
  int         m_len [4];
  logic       m_mux, m_dir, m_run;
  logic [1:0] m_col;

  initial begin
    m_h1 = 0; m_h2 = 0; m_prev_s = 0; m_db = 0;
    m_mux = 0; m_dir = 0; m_col = 0; m_run = 1;
    for (int i = 0; i < 4; i++) m_len[i] = 0;
    forever begin
      logic [3:0] s;
      logic [3:0] p;
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_h1 = 0; m_h2 = 0; m_prev_s = 0; m_db = 0;
        for (int i = 0; i < 4; i++) m_len[i] = 0;
        m_mux = 0; m_dir = 0; m_col = 0; m_run = 1;
      end else begin
        s = m_h2;
        p = 0;
        for (int i = 0; i < 4; i++) begin
          m_len[i] = (s[i] == m_prev_s[i]) ? m_len[i] + 1 : 1;
          if (s[i] != m_db[i] && m_len[i] >= DB) begin
            m_db[i] = s[i];
            p[i]    = s[i];
          end
        end
        m_prev_s = s;
        m_h2 = m_h1;
        m_h1 = bif.i_btn;
        if (p != 0) begin
          ev_t e;
          if (p[0]) m_mux = ~m_mux;
          if (p[1]) m_dir = ~m_dir;
          if (p[2]) m_col = (m_col + 2'd1) % 3;
          if (p[3]) m_run = ~m_run;
          e.cyc = cyc; e.press = p;
          e.mux = m_mux; e.dir = m_dir; e.col = m_col; e.run = m_run;
          q.push_back(e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected press whenever one is due or the DUT pulses.
  initial begin
    bit   pend = 0;
    ev_t  pe;
    forever begin
      logic [3:0] exp_p;
      @(negedge clk);
      if (pend) begin
        chk("ctrl_mux", int'(bif.o_mux_sel),   int'(pe.mux));
        chk("ctrl_dir", int'(bif.o_shift_dir), int'(pe.dir));
        chk("ctrl_col", int'(bif.o_color_sel), int'(pe.col));
        chk("ctrl_run", int'(bif.o_run),       int'(pe.run));
        pend = 0;
      end
      exp_p = (q.size() > 0 && q[0].cyc == cyc) ? q[0].press : 4'd0;
      if (bif.o_btn_press != 0 || exp_p != 0) begin
        chk("press", int'(bif.o_btn_press), int'(exp_p));
        if (exp_p != 0) begin
          pe   = q.pop_front();
          pend = 1;
        end
      end
      if (!rst) chk("btn_db", int'(bif.o_btn_db), int'(m_db));
      if (bif.o_color_sel == 2'd3) chk("color_not_3", 3, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_ctrl(input string name);
    chk({name, "_mux"}, int'(bif.o_mux_sel),   int'(m_mux));
    chk({name, "_dir"}, int'(bif.o_shift_dir), int'(m_dir));
    chk({name, "_col"}, int'(bif.o_color_sel), int'(m_col));
    chk({name, "_run"}, int'(bif.o_run),       int'(m_run));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_db"},    int'(bif.o_btn_db),    0);
    chk({name, "_press"}, int'(bif.o_btn_press), 0);
    chk({name, "_mux"},   int'(bif.o_mux_sel),   0);
    chk({name, "_dir"},   int'(bif.o_shift_dir), 0);
    chk({name, "_col"},   int'(bif.o_color_sel), 0);
    chk({name, "_run"},   int'(bif.o_run),       1);
  endtask

  // Edge index (0 = first edge after the call) at which press[bit] is seen.
  task automatic press_latency(input int bit_i, output int lat);
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bif.o_btn_press[bit_i] && lat < 0) lat = k;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bif.i_btn = 4'b0;
    tick(2);
    check_reset_state("reset");
    rst = 1'b0;
    tick(3);

    // Single press on btn[0]
    bif.i_btn = 4'b0001;
    press_latency(0, lat);
    chk("press0_latency", lat, 5);
    chk("mux_after_press0", int'(bif.o_mux_sel), 1);
    bif.i_btn = 4'b0000;
    tick(10);

    // Glitch shorter than the debounce window
    bif.i_btn = 4'b0010;
    tick(3);
    bif.i_btn = 4'b0000;
    tick(12);
    chk("glitch_db1", int'(bif.o_btn_db[1]), 0);
    chk("glitch_dir", int'(bif.o_shift_dir), 0);

    // Colour wrap
    for (int n = 0; n < 4; n++) begin
      bif.i_btn = 4'b0100;
      tick(10);
      bif.i_btn = 4'b0000;
      tick(10);
    end
    chk("color_wrap", int'(bif.o_color_sel), 1);

    // Simultaneous presses
    bif.i_btn = 4'b1001;
    tick(12);
    chk("simul_run", int'(bif.o_run), 0);
    chk("simul_mux", int'(bif.o_mux_sel), 0);
    bif.i_btn = 4'b0000;
    tick(10);
    check_ctrl("after_simul");

    // Reset in the middle of a debounce count
    bif.i_btn = 4'b0010;
    tick(4);
    rst = 1'b1;
    tick(2);
    check_reset_state("mid_reset");
    rst = 1'b0;
    press_latency(1, lat);
    chk("press1_after_reset", lat, 5);
    chk("dir_after_reset", int'(bif.o_shift_dir), 1);
    bif.i_btn = 4'b0000;
    tick(10);

    // Random held levels, including short bounces
    for (int n = 0; n < 400; n++) begin
      bif.i_btn = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 9));
    end
    bif.i_btn = 4'b0000;
    tick(20);
    check_ctrl("final");
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
